// File: rtl/neuron_mac_to_float.sv
// Neuron pre-activation: streams (x, w) pairs, accumulates onto a bias,
// and converts the fixed-point sum to an IEEE-754 single-precision result.
module neuron_mac_to_float #(
    parameter int N_INPUTS = 16,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ACC_W    = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic [31:0]       bias_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       y_out
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int MSB_W = $clog2(ACC_W);
    localparam int P_W   = 2 * DATA_W;
    localparam int EXT_W = ACC_W + 24;

    // ROUND packs the float; split from CONV2 to keep the shifter and
    // rounding adder in separate cycles.
    typedef enum logic [2:0] {
        ACCUM,
        DRAIN,
        CONV1,
        CONV2,
        ROUND,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [P_W-1:0]     p_q, p_d;
    logic               p_vld_q, p_vld_d;
    logic               sign_q, sign_d;
    logic               zero_q, zero_d;
    logic [ACC_W-1:0]   mag_q, mag_d;
    logic [MSB_W-1:0]   msb_q, msb_d;
    logic [23:0]        sig_q, sig_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic [7:0]         exp_q, exp_d;
    logic [31:0]        y_q, y_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic signed [P_W-1:0] prod;
    logic [ACC_W-1:0]   acc_abs;
    logic [MSB_W-1:0]   lead;
    logic [MSB_W-1:0]   shamt;
    logic [EXT_W-1:0]   norm;
    logic               rnd;
    logic [24:0]        sum25;
    logic               carry;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign accept    = in_valid & in_ready;
    assign prod      = $signed(x_in) * $signed(w_in);

    // Magnitude of the accumulator; the most negative value maps exactly.
    always_comb begin
        acc_abs = acc_q;
        if (acc_q[ACC_W-1]) begin
            acc_abs = ~acc_q + ACC_W'(1);
        end
    end

    // Position of the leading one of the magnitude.
    always_comb begin
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (acc_abs[i]) begin
                lead = MSB_W'(i);
            end
        end
    end

    // Left-justify the magnitude so its leading one lands at the top bit.
    always_comb begin
        shamt = MSB_W'(ACC_W - 1) - msb_q;
        norm  = {mag_q, 24'b0} << shamt;
    end

    // Round-to-nearest-even on the normalised significand.
    always_comb begin
        rnd   = guard_q & (sticky_q | sig_q[0]);
        sum25 = {1'b0, sig_q} + 25'(rnd);
        carry = sum25[24] & ~sum25[23];
    end

    // Next-state and datapath for accumulation and conversion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        p_d         = p_q;
        p_vld_d     = accept;
        sign_d      = sign_q;
        zero_d      = zero_q;
        mag_d       = mag_q;
        msb_d       = msb_q;
        sig_d       = sig_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        exp_d       = exp_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            p_d = prod;
        end
        if (p_vld_q) begin
            acc_d = acc_q + {{(ACC_W-P_W){p_q[P_W-1]}}, p_q};
        end
        if (accept && cnt_q == '0) begin
            acc_d = {{(ACC_W-32){bias_in[31]}}, bias_in};
        end

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                state_d = CONV1;
            end
            CONV1: begin
                sign_d  = acc_q[ACC_W-1];
                mag_d   = acc_abs;
                msb_d   = lead;
                zero_d  = (acc_q == '0);
                state_d = CONV2;
            end
            CONV2: begin
                sig_d    = norm[EXT_W-1 -: 24];
                guard_d  = norm[EXT_W-25];
                sticky_d = |norm[EXT_W-26:0];
                exp_d    = 8'd127 + 8'(msb_q) - 8'(2 * FRAC_W);
                state_d  = ROUND;
            end
            ROUND: begin
                if (zero_q) begin
                    y_d = 32'h0000_0000;
                end else begin
                    y_d = {sign_q, exp_q + {7'b0, carry}, sum25[22:0]};
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            msb_q       <= '0;
            sig_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            exp_q       <= '0;
            y_q         <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            p_vld_q     <= p_vld_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            mag_q       <= mag_d;
            msb_q       <= msb_d;
            sig_q       <= sig_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            exp_q       <= exp_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
